// File: rtl/playback_sequencer_if.sv
// Control/data bundle between the game FSM, pulse timer, pattern RAM and the
// playback sequencer. master = environment side, slave = sequencer side.
interface playback_sequencer_if;
    logic       start;
    logic       abort;
    logic [4:0] seq_len;
    logic [3:0] speed;
    logic [1:0] color_data;
    logic       variable_pulse;
    logic       fast_pulse;
    logic [3:0] color_addr;
    logic [3:0] pulse_index;
    logic       delay_reset;
    logic [3:0] led;
    logic       busy;
    logic       done;

    modport master (
        output start, abort, seq_len, speed, color_data, variable_pulse, fast_pulse,
        input  color_addr, pulse_index, delay_reset, led, busy, done
    );

    modport slave (
        input  start, abort, seq_len, speed, color_data, variable_pulse, fast_pulse,
        output color_addr, pulse_index, delay_reset, led, busy, done
    );
endinterface

// File: rtl/playback_sequencer.sv
// Simon pattern playback: per color, fetch from RAM, light LED for the variable
// on-time, blank for the fixed gap, restarting the shared timer at each phase.
module playback_sequencer #(
    parameter int MAX_LEN = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    playback_sequencer_if.slave  bus
);
    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_ON, S_GAP, S_DONE} state_t;

    localparam logic [4:0] LEN_MAX = 5'(MAX_LEN);

    state_t     r_state, w_state_nxt;
    logic [3:0] r_idx,   w_idx_nxt;
    logic [4:0] r_len,   w_len_nxt;
    logic [3:0] r_spd,   w_spd_nxt;
    logic [3:0] r_led,   w_led_nxt;
    logic       r_dr,    w_dr_nxt;
    logic       w_vp, w_fp, w_last;

    // Pulses arriving while the timer is being restarted are stale.
    assign w_vp   = bus.variable_pulse & ~r_dr;
    assign w_fp   = bus.fast_pulse & ~r_dr;
    assign w_last = ({1'b0, r_idx} == (r_len - 5'd1));

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_len_nxt   = r_len;
        w_spd_nxt   = r_spd;
        w_led_nxt   = r_led;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_len_nxt   = (bus.seq_len > LEN_MAX) ? LEN_MAX : bus.seq_len;
                    w_spd_nxt   = bus.speed;
                    w_idx_nxt   = 4'd0;
                    w_state_nxt = (bus.seq_len == 5'd0) ? S_DONE : S_FETCH;
                end
            end
            S_FETCH: begin
                w_led_nxt   = 4'b0001 << bus.color_data;
                w_state_nxt = S_ON;
            end
            S_ON: begin
                if (w_vp) begin
                    w_led_nxt   = 4'd0;
                    w_state_nxt = S_GAP;
                end
            end
            S_GAP: begin
                if (w_fp) begin
                    if (w_last) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_idx_nxt   = r_idx + 4'd1;
                        w_state_nxt = S_FETCH;
                    end
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
        if (bus.abort) begin
            w_state_nxt = S_IDLE;
            w_idx_nxt   = 4'd0;
            w_led_nxt   = 4'd0;
        end
        // Timer runs only in ON and in GAP after its entry cycle.
        w_dr_nxt = (w_state_nxt != S_ON) && !(w_state_nxt == S_GAP && r_state == S_GAP);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_idx   <= 4'd0;
            r_len   <= 5'd0;
            r_spd   <= 4'd0;
            r_led   <= 4'd0;
            r_dr    <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_len   <= w_len_nxt;
            r_spd   <= w_spd_nxt;
            r_led   <= w_led_nxt;
            r_dr    <= w_dr_nxt;
        end
    end

    assign bus.color_addr  = r_idx;
    assign bus.pulse_index = r_spd;
    assign bus.led         = r_led;
    assign bus.delay_reset = r_dr;
    assign bus.busy        = (r_state != S_IDLE);
    assign bus.done        = (r_state == S_DONE);
endmodule
